pwm_cfg_ctrl: RTL

Configuration sequencer for the PWM path. It accepts frequency (`pow2`/`pow5`) and duty requests from the host-side logic over a valid/ready handshake and range-checks the duty. It holds an accepted request in a shadow register and applies it glitch-free only at a PWM period boundary. When the frequency changes, it also flushes the divider with a short synchronous restart. It sits between the command/UI logic and `pwm_divider` plus the PWM compare stage.

---
 rtl/pwm_cfg_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_cfg_ctrl.sv
// pwm_cfg_ctrl: configuration sequencer for the PWM path.
// Accepts {pow2, pow5, duty} requests over valid/ready, rejects duty > 100,
// holds accepted requests in a shadow register and applies them only at a
// PWM period boundary (or after a timeout). A frequency change additionally
// restarts pwm_divider by holding div_rstn_o low for FLUSH_CYC cycles.
//
// Ports:
//   clk_i          system clock
//   rstn_i         synchronous active-low reset
//   cfg_valid_i    request valid
//   cfg_ready_o    controller can accept a request (IDLE only)
//   cfg_pow2_i     requested divide-by-2^n exponent
//   cfg_pow5_i     requested divide-by-5^n exponent
//   cfg_duty_i     requested duty, percent
//   period_end_i   one-cycle pulse on the last cycle of a PWM period
//   pow2_o/pow5_o  active exponents to pwm_divider
//   duty_o         active duty to the compare stage
//   div_rstn_o     active-low synchronous restart for pwm_divider
//   cfg_done_o     pulse: request fully applied
//   cfg_err_o      pulse: request rejected (duty out of range)
//   timeout_o      pulse: apply forced by the timeout counter
module pwm_cfg_ctrl #(
    parameter int unsigned DUTY_W    = 7,
    parameter int unsigned DUTY_RST  = 50,
    parameter int unsigned FLUSH_CYC = 2,        // legal range 1..15
    parameter int unsigned TIMEOUT   = 1_100_000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [1:0]        cfg_pow2_i,
    input  logic [1:0]        cfg_pow5_i,
    input  logic [DUTY_W-1:0] cfg_duty_i,
    input  logic              period_end_i,
    output logic [1:0]        pow2_o,
    output logic [1:0]        pow5_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic              div_rstn_o,
    output logic              cfg_done_o,
    output logic              cfg_err_o,
    output logic              timeout_o
);

    localparam int unsigned TCNT_W   = 21;
    localparam int unsigned FCNT_W   = 4;
    localparam int unsigned DUTY_MAX = 100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sh_pow2_q, sh_pow2_d;
    logic [1:0]          sh_pow5_q, sh_pow5_d;
    logic [DUTY_W-1:0]   sh_duty_q, sh_duty_d;
    logic                sh_fchg_q, sh_fchg_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [1:0]          pow2_q, pow2_d;
    logic [1:0]          pow5_q, pow5_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                div_rstn_q, div_rstn_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                to_q, to_d;

    logic                xfer;
    logic                t_term;

    assign xfer   = cfg_valid_i & ready_q;
    assign t_term = (tcnt_q == TCNT_W'(TIMEOUT - 1));

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            sh_pow2_q  <= 2'd0;
            sh_pow5_q  <= 2'd0;
            sh_duty_q  <= '0;
            sh_fchg_q  <= 1'b0;
            tcnt_q     <= '0;
            fcnt_q     <= '0;
            pow2_q     <= 2'd0;
            pow5_q     <= 2'd0;
            duty_q     <= DUTY_W'(DUTY_RST);
            div_rstn_q <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_pow2_q  <= sh_pow2_d;
            sh_pow5_q  <= sh_pow5_d;
            sh_duty_q  <= sh_duty_d;
            sh_fchg_q  <= sh_fchg_d;
            tcnt_q     <= tcnt_d;
            fcnt_q     <= fcnt_d;
            pow2_q     <= pow2_d;
            pow5_q     <= pow5_d;
            duty_q     <= duty_d;
            div_rstn_q <= div_rstn_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            to_q       <= to_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        sh_pow2_d  = sh_pow2_q;
        sh_pow5_d  = sh_pow5_q;
        sh_duty_d  = sh_duty_q;
        sh_fchg_d  = sh_fchg_q;
        tcnt_d     = tcnt_q;
        fcnt_d     = fcnt_q;
        pow2_d     = pow2_q;
        pow5_d     = pow5_q;
        duty_d     = duty_q;
        div_rstn_d = 1'b1;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        to_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (xfer) begin
                    if (cfg_duty_i > DUTY_W'(DUTY_MAX)) begin
                        err_d = 1'b1;
                    end else begin
                        sh_pow2_d = cfg_pow2_i;
                        sh_pow5_d = cfg_pow5_i;
                        sh_duty_d = cfg_duty_i;
                        sh_fchg_d = (cfg_pow2_i != pow2_q) || (cfg_pow5_i != pow5_q);
                        tcnt_d    = '0;
                        ready_d   = 1'b0;
                        state_d   = PEND;
                    end
                end
            end

            PEND: begin
                tcnt_d = tcnt_q + TCNT_W'(1);
                if (period_end_i || t_term) begin
                    pow2_d = sh_pow2_q;
                    pow5_d = sh_pow5_q;
                    duty_d = sh_duty_q;
                    // A boundary landing on the terminal count is a normal apply.
                    to_d   = t_term & ~period_end_i;
                    if (sh_fchg_q) begin
                        div_rstn_d = 1'b0;
                        fcnt_d     = FCNT_W'(FLUSH_CYC);
                        state_d    = FLUSH;
                    end else begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            FLUSH: begin
                // fcnt_q counts the low cycles still to be shown, including this one.
                if (fcnt_q <= FCNT_W'(1)) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_rstn_d = 1'b0;
                    fcnt_d     = fcnt_q - FCNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg_ready_o = ready_q;
    assign pow2_o      = pow2_q;
    assign pow5_o      = pow5_q;
    assign duty_o      = duty_q;
    assign div_rstn_o  = div_rstn_q;
    assign cfg_done_o  = done_q;
    assign cfg_err_o   = err_q;
    assign timeout_o   = to_q;

endmodule
